// File: rtl/m_lsu_ctrl_if.sv
// Data bus between the load/store controller (master) and the memory slave.
// Single outstanding transfer: req stays high until ack; ack is only
// meaningful while req is high.
//   req   master->slave  transfer request
//   we    master->slave  write enable
//   addr  master->slave  word-aligned address
//   wdata master->slave  lane-replicated store data
//   sel   master->slave  byte enables
//   rdata slave->master  read data
//   ack   slave->master  transfer complete
interface m_lsu_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, sel, input rdata, ack);
  modport slave  (input req, we, addr, wdata, sel, output rdata, ack);
endinterface

// File: rtl/m_lsu_ctrl.sv
// Load/store unit controller for the EXE/MEM stage. Takes one memory op at a
// time, runs it on a single-outstanding data bus, formats load data and store
// byte lanes, and talks to the hazard unit via lsu_req/lsu_ack/lsu_flush.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   lsu_valid_i/is_load_i   op present / load(1) or store(0)
//   lsu_funct3_i            RV32 load/store funct3
//   lsu_addr_i/lsu_wdata_i  effective address / store data
//   lsu_flush_i             abort request from the hazard unit
//   lsu_req_o/lsu_ack_o     stall request / one-cycle completion pulse
//   lsu_rdata_o             formatted load result (valid with lsu_ack_o)
//   ld_/st_misalign_o       misaligned access pulses
//   bus_err_o               bus timeout pulse, concurrent with lsu_ack_o
//   dbus                    data bus master port
//
// state | meaning
// IDLE  | no transfer; issue or flag misalignment
// BUSY  | transfer on the bus, result will be reported
// DRAIN | transfer aborted by flush, waiting for bus to finish silently
module m_lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid_i,
  input  logic        lsu_is_load_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_flush_i,
  output logic        lsu_req_o,
  output logic        lsu_ack_o,
  output logic [31:0] lsu_rdata_o,
  output logic        ld_misalign_o,
  output logic        st_misalign_o,
  output logic        bus_err_o,
  m_lsu_ctrl_if.master dbus
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        misaligned, mis_op, issue, timeout;
  logic [3:0]  sel_new;
  logic [31:0] wdata_new, rd_shift, load_fmt;
  logic [15:0] rd_half;

  assign misaligned = ((lsu_funct3_i[1:0] == 2'b01) & lsu_addr_i[0]) |
                      ((lsu_funct3_i[1:0] == 2'b10) & (lsu_addr_i[1:0] != 2'b00));
  assign mis_op  = (state_q == IDLE) & lsu_valid_i & misaligned & ~lsu_flush_i;
  assign issue   = (state_q == IDLE) & lsu_valid_i & ~misaligned & ~lsu_flush_i;
  // This cycle is the TIMEOUT-th one spent waiting, counting from the first bus cycle.
  assign timeout = (cnt_q == CNT_LAST) & ~dbus.ack;

  always_comb begin
    sel_new   = 4'b1111;
    wdata_new = lsu_wdata_i;
    if (!lsu_is_load_i) begin
      case (lsu_funct3_i[1:0])
        2'b00: begin
          sel_new   = 4'b0001 << lsu_addr_i[1:0];
          wdata_new = {4{lsu_wdata_i[7:0]}};
        end
        2'b01: begin
          sel_new   = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{lsu_wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_shift = dbus.rdata >> {off_q, 3'b000};
    rd_half  = off_q[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_fmt = {{24{~funct3_q[2] & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_fmt = {{16{~funct3_q[2] & rd_half[15]}}, rd_half};
      default: load_fmt = dbus.rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      off_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = BUSY;
          cnt_d    = '0;
          we_d     = ~lsu_is_load_i;
          addr_d   = {lsu_addr_i[31:2], 2'b00};
          sel_d    = sel_new;
          wdata_d  = wdata_new;
          funct3_d = lsu_funct3_i;
          off_d    = lsu_addr_i[1:0];
        end
      end
      BUSY: begin
        if (dbus.ack || timeout) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (lsu_flush_i) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The request cannot be withdrawn, so wait for ack or timeout.
        if (dbus.ack || timeout) state_d = IDLE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lsu_req_o     = 1'b0;
    lsu_ack_o     = 1'b0;
    lsu_rdata_o   = '0;
    ld_misalign_o = 1'b0;
    st_misalign_o = 1'b0;
    bus_err_o     = 1'b0;
    case (state_q)
      IDLE: begin
        lsu_req_o     = issue;
        ld_misalign_o = mis_op & lsu_is_load_i;
        st_misalign_o = mis_op & ~lsu_is_load_i;
      end
      BUSY: begin
        // A flush in the completing cycle still lets the transfer finish,
        // but the pipeline no longer wants the result.
        if (!lsu_flush_i) begin
          if (dbus.ack) begin
            lsu_ack_o = 1'b1;
            if (!we_q) lsu_rdata_o = load_fmt;
          end else if (timeout) begin
            lsu_ack_o = 1'b1;
            bus_err_o = 1'b1;
          end
        end
      end
      DRAIN: lsu_req_o = lsu_valid_i;
      default: ;
    endcase
  end

  assign dbus.req   = (state_q != IDLE);
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.sel   = sel_q;
  assign dbus.wdata = wdata_q;

endmodule
